// File: rtl/rv_ifu_pkg.sv
// Shared widths, reset defaults and PC helpers for the instruction fetch unit.
package rv_ifu_pkg;

   localparam int unsigned XLEN           = 32;
   localparam int unsigned DATA_WIDTH_DEF = 32;
   localparam int unsigned ROM_DEPTH_DEF  = 256;
   localparam int unsigned FIFO_DEPTH_DEF = 2;

   localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [XLEN-1:0] INSTR_BYTES  = XLEN'(4);

   // Redirect targets are forced onto a word boundary.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] pc);
      return pc & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/rv_ifu_fifo.sv
// Prefetch FIFO: power-of-two depth, push/pop/flush, registered head storage and count.
module rv_ifu_fifo #(
   parameter int unsigned  WIDTH = 64,
   parameter int unsigned  DEPTH = 2,
   localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count,
   output logic             not_empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    count_nxt;

   // Flush wins; simultaneous push and pop leave the count unchanged.
   always_comb begin
      count_nxt = count;
      if (flush)
         count_nxt = '0;
      else if (push && !pop)
         count_nxt = count + CW'(1);
      else if (pop && !push)
         count_nxt = count - CW'(1);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         not_empty <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++)
            mem[i] <= '0;
      end else begin
         count     <= count_nxt;
         not_empty <= (count_nxt != '0);
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push) begin
               mem[wr_ptr] <= wdata;
               wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop)
               rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/rv_ifu.sv
// Instruction fetch unit: owns fetch_pc, addresses the ROM and queues {pc, instr} for decode.
module rv_ifu
   import rv_ifu_pkg::*;
#(
   parameter int unsigned     FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
   parameter int unsigned     DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned     ROM_DEPTH  = ROM_DEPTH_DEF,
   localparam int unsigned    AW         = $clog2(ROM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rstn,
   output logic [AW-1:0]         rom_addr_o,
   input  logic [DATA_WIDTH-1:0] rom_data_i,
   input  logic                  redirect_i,
   input  logic [XLEN-1:0]       redirect_pc_i,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic [XLEN-1:0]       pc_o,
   output logic                  valid_o,
   input  logic                  ready_i
);

   localparam int unsigned EW = XLEN + DATA_WIDTH;
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic [XLEN-1:0] fetch_pc;
   logic [CW-1:0]   count;
   logic [EW-1:0]   head;
   logic            pop;
   logic            push;

   assign pop  = valid_o & ready_i;
   // A full FIFO may still accept when decode frees the head in the same cycle.
   assign push = !redirect_i & ((count < CW'(FIFO_DEPTH)) | pop);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         fetch_pc <= RESET_PC;
      else if (redirect_i)
         fetch_pc <= word_align(redirect_pc_i);
      else if (push)
         fetch_pc <= fetch_pc + INSTR_BYTES;
   end

   // Truncation makes fetches past the ROM end alias back to word 0.
   assign rom_addr_o = fetch_pc[AW+1:2];

   rv_ifu_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (push),
      .pop       (pop),
      .flush     (redirect_i),
      .wdata     ({fetch_pc, rom_data_i}),
      .head      (head),
      .count     (count),
      .not_empty (valid_o)
   );

   assign pc_o    = head[EW-1:DATA_WIDTH];
   assign instr_o = head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_rv_ifu.sv
// Self-checking bench for rv_ifu against a PC-stream reference model.
module tb_rv_ifu;

   localparam int unsigned FIFO_DEPTH = 2;
   localparam int unsigned ROM_DEPTH  = 32;
   localparam int unsigned AW         = $clog2(ROM_DEPTH);

   logic          clk = 1'b0;
   logic          rstn;
   logic [AW-1:0] rom_addr_o;
   logic [31:0]   rom_data_i;
   logic          redirect_i;
   logic [31:0]   redirect_pc_i;
   logic [31:0]   instr_o;
   logic [31:0]   pc_o;
   logic          valid_o;
   logic          ready_i;

   logic [31:0] rom [ROM_DEPTH];
   assign rom_data_i = rom[rom_addr_o];

   int checks = 0;
   int errors = 0;

   // Reference model: fetch address, next PC decode should see, and prefetched entries.
   int          m_count;
   logic [31:0] m_fetch;
   logic [31:0] m_head;

   always #5 clk = ~clk;

   rv_ifu #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .RESET_PC   (32'h0000_0000),
      .DATA_WIDTH (32),
      .ROM_DEPTH  (ROM_DEPTH)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .rom_addr_o    (rom_addr_o),
      .rom_data_i    (rom_data_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .instr_o       (instr_o),
      .pc_o          (pc_o),
      .valid_o       (valid_o),
      .ready_i       (ready_i)
   );

   function automatic logic [31:0] rom_at(input logic [31:0] pc);
      return rom[(pc >> 2) % ROM_DEPTH];
   endfunction

   // Compare current outputs with the model, drive one cycle of inputs, advance the model.
   task automatic step(input logic rdy, input logic red, input logic [31:0] rpc);
      logic pop;
      logic push;
      logic [AW-1:0] exp_addr;
      exp_addr = AW'((m_fetch >> 2) % ROM_DEPTH);
      checks++;
      if (valid_o !== (m_count != 0)) begin
         errors++;
         $display("FAIL step_valid: got %b expected %b", valid_o, (m_count != 0));
      end
      checks++;
      if (rom_addr_o !== exp_addr) begin
         errors++;
         $display("FAIL step_rom_addr: got %0d expected %0d", rom_addr_o, exp_addr);
      end
      if (m_count != 0) begin
         checks++;
         if (pc_o !== m_head) begin
            errors++;
            $display("FAIL step_pc: got %h expected %h", pc_o, m_head);
         end
         checks++;
         if (instr_o !== rom_at(m_head)) begin
            errors++;
            $display("FAIL step_instr: got %h expected %h", instr_o, rom_at(m_head));
         end
      end
      ready_i       = rdy;
      redirect_i    = red;
      redirect_pc_i = rpc;
      pop = (m_count != 0) && rdy;
      if (red) begin
         m_count = 0;
         m_fetch = rpc & 32'hFFFF_FFFC;
         m_head  = m_fetch;
      end else begin
         push = (m_count < int'(FIFO_DEPTH)) || pop;
         if (pop)  m_head  = m_head + 32'd4;
         if (push) m_fetch = m_fetch + 32'd4;
         m_count = m_count + int'(push) - int'(pop);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_reset();
      m_count = 0;
      m_fetch = 32'h0;
      m_head  = 32'h0;
   endtask

   task automatic do_reset();
      rstn          = 1'b0;
      ready_i       = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = 32'h0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      model_reset();
   endtask

   task automatic expect32(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      ready_i = 1'b0;
      redirect_i = 1'b0;
      redirect_pc_i = 32'h0;
      repeat (2) @(negedge clk);
      expect32("reset_valid", 32'(valid_o), 32'd0);
      expect32("reset_pc", pc_o, 32'h0);
      expect32("reset_instr", instr_o, 32'h0);
      expect32("reset_rom_addr", 32'(rom_addr_o), 32'd0);
      rstn = 1'b1;
      model_reset();
   endtask

   task automatic test_stream();
      step(1'b1, 1'b0, 32'h0);
      expect32("stream_first_valid", 32'(valid_o), 32'd1);
      expect32("stream_first_pc", pc_o, 32'h0);
      expect32("stream_first_instr", instr_o, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      expect32("stream_pc4", pc_o, 32'h4);
      step(1'b1, 1'b0, 32'h0);
      expect32("stream_pc8", pc_o, 32'h8);
      step(1'b1, 1'b0, 32'h0);
      expect32("stream_pc12", pc_o, 32'hC);
   endtask

   task automatic test_stall();
      do_reset();
      repeat (5) step(1'b0, 1'b0, 32'h0);
      expect32("stall_rom_addr", 32'(rom_addr_o), 32'd2);
      expect32("stall_head_pc", pc_o, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      expect32("stall_drain_pc4", pc_o, 32'h4);
      step(1'b1, 1'b0, 32'h0);
      expect32("stall_drain_pc8", pc_o, 32'h8);
   endtask

   task automatic test_redirect();
      step(1'b1, 1'b1, 32'h40);
      expect32("redirect_bubble", 32'(valid_o), 32'd0);
      step(1'b1, 1'b0, 32'h0);
      expect32("redirect_pc", pc_o, 32'h40);
      expect32("redirect_instr", instr_o, 32'd16);
      step(1'b1, 1'b1, 32'h43);
      step(1'b1, 1'b0, 32'h0);
      expect32("redirect_unaligned_pc", pc_o, 32'h40);
   endtask

   task automatic test_redirect_pop_full();
      repeat (3) step(1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b1, 32'h200);
      expect32("flush_bubble", 32'(valid_o), 32'd0);
      step(1'b1, 1'b0, 32'h0);
      expect32("flush_target_pc", pc_o, 32'h200);
      expect32("flush_target_instr", instr_o, rom[0]);
      step(1'b1, 1'b0, 32'h0);
      expect32("flush_next_pc", pc_o, 32'h204);
   endtask

   task automatic test_wrap();
      step(1'b1, 1'b1, 32'h7C);
      expect32("wrap_addr_last", 32'(rom_addr_o), 32'd31);
      step(1'b1, 1'b0, 32'h0);
      expect32("wrap_addr_zero", 32'(rom_addr_o), 32'd0);
      step(1'b1, 1'b0, 32'h0);
      expect32("wrap_pc", pc_o, 32'h80);
      expect32("wrap_instr", instr_o, rom[0]);
   endtask

   task automatic test_async_reset();
      repeat (3) step(1'b0, 1'b0, 32'h0);
      @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      expect32("async_valid", 32'(valid_o), 32'd0);
      expect32("async_pc", pc_o, 32'h0);
      expect32("async_rom_addr", 32'(rom_addr_o), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      model_reset();
      step(1'b1, 1'b0, 32'h0);
      expect32("async_restart_pc", pc_o, 32'h0);
   endtask

   task automatic test_random();
      for (int i = 0; i < int'(ROM_DEPTH); i++)
         rom[i] = $urandom;
      do_reset();
      for (int n = 0; n < 600; n++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom);
   endtask

   initial begin
      for (int i = 0; i < int'(ROM_DEPTH); i++)
         rom[i] = 32'(i);
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_redirect_pop_full();
      test_wrap();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
